// File: rtl/busmux_pkg.sv
// Shared types and constants for the arbitrated bus multiplexer.
// Holds the FSM state encoding, the mode constants and the default sizes.
package busmux_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_SRC_DEF  = 24;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/arb_busmux_rr_arbiter.sv
// Combinational round-robin search: first asserted request strictly after ptr,
// wrapping from N_SRC-1 back to 0. ptr itself is searched last.
module rr_arbiter
    import busmux_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand_s;
    logic             hit_s;

    // Walk offsets 1..N_SRC from ptr; the first hit wins and masks later ones
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand_s      = SEL_W'((int'(ptr) + k) % N_SRC);
            hit_s       = !any && req[cand_s];
            gnt[cand_s] = gnt[cand_s] | hit_s;
            idx         = hit_s ? cand_s : idx;
            any         = any | hit_s;
        end
    end

endmodule

// File: rtl/arb_busmux.sv
// Registered bus multiplexer with direct-select and round-robin arbitrated
// modes, a one-word output holding stage with ready handshake, and burst lock.
module arb_busmux
    import busmux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_SRC  = N_SRC_DEF,
    parameter int SEL_W  = $clog2(N_SRC)
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_req,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    lock,
    input  logic                    bus_ready,
    output logic [DATA_W-1:0]       bus_out,
    output logic                    bus_valid,
    output logic [SEL_W-1:0]        bus_src,
    output logic [N_SRC-1:0]        grant
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SEL_W-1:0]   ptr_r;
    logic [SEL_W-1:0]   ptr_nxt_s;
    logic               load_s;
    logic               sel_ok_s;
    logic               owner_keep_s;
    logic               cap_s;
    logic               zero_s;
    logic [SEL_W-1:0]   cap_idx_s;
    logic [DATA_W-1:0]  cap_word_s;
    logic [N_SRC-1:0]   arb_gnt_s;
    logic [SEL_W-1:0]   arb_idx_s;
    logic               arb_any_s;

    function automatic logic [N_SRC-1:0] dec_onehot(input logic [SEL_W-1:0] i);
        logic [N_SRC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    rr_arbiter #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W)
    ) u_rr (
        .req (src_req),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Load-cycle decision: which source (if any) is captured and where ptr goes
    always_comb begin
        load_s       = (state_r == IDLE) || bus_ready;
        sel_ok_s     = {1'b0, sel} < (SEL_W + 1)'(N_SRC);
        owner_keep_s = lock && src_req[bus_src];
        cap_s        = 1'b0;
        zero_s       = 1'b0;
        cap_idx_s    = bus_src;
        ptr_nxt_s    = ptr_r;
        if (!load_s) begin
            cap_s = 1'b0;
        end else if (mode == MODE_DIRECT) begin
            if (sel_ok_s) begin
                cap_s     = 1'b1;
                cap_idx_s = sel;
            end else begin
                zero_s = 1'b1;
            end
        end else if (owner_keep_s) begin
            // Burst lock: regrant the owner without rotating priority
            cap_s     = 1'b1;
            cap_idx_s = bus_src;
        end else if (arb_any_s) begin
            cap_s     = 1'b1;
            cap_idx_s = arb_idx_s;
            ptr_nxt_s = arb_idx_s;
        end else begin
            cap_s = 1'b0;
        end
    end

    // Next-state: a stalled word stays in HOLD; a load goes wherever the capture lands
    always_comb begin
        state_nxt_s = state_r;
        if (!load_s) begin
            state_nxt_s = state_r;
        end else if (cap_s) begin
            state_nxt_s = HOLD;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Source word mux driven by the chosen capture index
    always_comb begin
        cap_word_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cap_word_s = (cap_idx_s == SEL_W'(i)) ? src_data[i*DATA_W +: DATA_W] : cap_word_s;
        end
    end

    // Output registers, priority pointer and the one-cycle grant pulse
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
            grant     <= '0;
            ptr_r     <= SEL_W'(N_SRC - 1);
        end else begin
            bus_valid <= (state_nxt_s == HOLD);
            ptr_r     <= ptr_nxt_s;
            if (cap_s) begin
                bus_out <= cap_word_s;
                bus_src <= cap_idx_s;
                grant   <= dec_onehot(cap_idx_s);
            end else if (zero_s) begin
                bus_out <= '0;
                bus_src <= bus_src;
                grant   <= '0;
            end else begin
                bus_out <= bus_out;
                bus_src <= bus_src;
                grant   <= '0;
            end
        end
    end

endmodule

// File: doc/arb_busmux.md
ARB_BUSMUX -- requirements
Module: arb_busmux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning bus word width in bits.
REQ-002 SHALL have parameter N_SRC, default 24, meaning number of bus sources (index 0..N_SRC-1).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_SRC), meaning width of source index fields.
REQ-004 SHALL have port clock, input, 1, meaning single clock with all state updating on its rising edge.
REQ-005 SHALL have port clear, input, 1, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port src_data, input, N_SRC*DATA_W, meaning flattened source words, with source i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port src_req, input, N_SRC, meaning per-source request, used in arbitrated mode.
REQ-008 SHALL have port mode, input, 1, meaning 0 = direct select, 1 = round-robin arbitration.
REQ-009 SHALL have port sel, input, SEL_W, meaning source index in direct mode.
REQ-010 SHALL have port lock, input, 1, meaning hold arbitration on the current owner (burst).
REQ-011 SHALL have port bus_ready, input, 1, meaning sink accepts bus_out this cycle.
REQ-012 SHALL have port bus_out, output, DATA_W, meaning registered bus word.
REQ-013 SHALL have port bus_valid, output, 1, meaning bus_out holds a word.
REQ-014 SHALL have port bus_src, output, SEL_W, meaning index of the source that drove bus_out.
REQ-015 SHALL have port grant, output, N_SRC, meaning one-hot, one-cycle pulse on the source captured this cycle.

Function
REQ-016 SHALL implement FSM states IDLE (bus_valid=0) and HOLD (bus_valid=1).
REQ-017 SHALL define a load cycle as one where (state==IDLE) or (state==HOLD and bus_ready==1).
REQ-018 SHALL, in direct mode on a load cycle with sel<N_SRC, register src_data[sel] into bus_out, set bus_src=sel, pulse grant[sel], and go to HOLD, giving 1-cycle latency.
REQ-019 SHALL, in direct mode on a load cycle with sel>=N_SRC, register bus_out=0, produce no grant, and go to IDLE.
REQ-020 SHALL, in arbitrated mode on a load cycle, grant the first asserted src_req searching from ptr+1 upward with wrap from N_SRC-1 to 0, capture that source, and set ptr to the granted index.
REQ-021 SHALL, in arbitrated mode with no src_req asserted on a load cycle, go to IDLE, leave bus_out unchanged, and produce no grant.
REQ-022 SHALL, when lock=1 and the current owner (bus_src) has src_req asserted on a load cycle in arbitrated mode, regrant the owner and not advance ptr.
REQ-023 SHALL, when lock=1 and the owner has dropped its request, arbitrate normally.
REQ-024 SHALL, in HOLD with bus_ready=0, hold bus_out, bus_src and bus_valid stable, keep grant all-zero, and ignore sel, mode and src_req.
REQ-025 SHALL, in HOLD with bus_ready=1, accept the word and perform a load in the same cycle, allowing back-to-back words at one word per clock.
REQ-026 SHALL sample mode changes only on load cycles, so an in-flight word is never altered.
REQ-027 SHALL keep grant to at most one bit set in every cycle.

Reset
REQ-028 SHALL, while clear=1, immediately force bus_out=0, bus_valid=0, bus_src=0, grant=0, state=IDLE, and ptr=N_SRC-1, so that source 0 has first priority.
REQ-029 SHALL, on clear asserted mid-transfer, discard the held word without acceptance, and resume with the first rising edge after clear deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE, HOLD), the mode constants (MODE_DIRECT=0, MODE_RR=1), and default DATA_W/N_SRC in shared package busmux_pkg.
REQ-031 SHALL implement the combinational round-robin search (req, ptr -> one-hot grant, index, any) as sub-module rr_arbiter, parametrised by N_SRC.
REQ-032 SHALL keep all registers in arb_busmux; rr_arbiter SHALL be purely combinational.

Verification
REQ-033 SHALL cover direct select: mode=0, sel=20, src20=32'hDEADBEEF, bus_ready=1 -> next cycle bus_out=DEADBEEF, bus_src=20, bus_valid=1, grant[20] pulsed.
REQ-034 SHALL cover an out-of-range select: mode=0, sel=30 (N_SRC=24) -> bus_out=0, bus_valid=0, grant=0.
REQ-035 SHALL cover round-robin wrap: mode=1, src_req bits {0,5,23} held, bus_ready=1 -> grants in order 0,5,23,0,5 on consecutive cycles.
REQ-036 SHALL cover stall: HOLD with word 32'h12345678, bus_ready=0 for 3 cycles while sel and src_req toggle -> bus_out, bus_src stable and grant=0, then bus_ready=1 -> next source loaded.
REQ-037 SHALL cover lock burst: mode=1, src_req {3,7}, owner=3, lock=1 for 4 cycles -> grant[3] 4 times; lock=0 -> next grant is 7.
REQ-038 SHALL cover reset mid-transfer: clear pulsed asynchronously while bus_valid=1 -> outputs 0 immediately; after release with src_req {0,1} -> first grant is 0.
